// File: rtl/turbo_frame_packer.sv
// Packs the decoder's serial hard-decision bits LSB-first into WORD_BITS words behind a small FIFO.
// Optional macro TURBO_PACKER_FRAME_COUNT_EN adds a 16-bit count of completed frames popped.
module turbo_frame_packer #(
  parameter int unsigned N          = 8,
  parameter int unsigned WORD_BITS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_last,
`ifdef TURBO_PACKER_FRAME_COUNT_EN
  output logic [15:0]          frame_count,
`endif
  output logic                 overflow
);

  localparam int unsigned BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned FW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BitLast   = BW'(WORD_BITS - 1);
  localparam logic [FW-1:0] FrameLast = FW'(N - 1);

  logic [WORD_BITS-1:0] shift_q, shift_d, push_word;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
  logic                 frame_end, push;

  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic [WORD_BITS:0]   mem_q [FIFO_DEPTH];
  logic [WORD_BITS:0]   head;
  logic                 empty, full, pop, push_ok, overflow_q, overflow_d;

  // Packer: shift_q only ever holds bits below bit_cnt_q, so the final word is zero-padded.
  always_comb begin
    frame_end   = (frame_cnt_q == FrameLast);
    push        = in_valid && ((bit_cnt_q == BitLast) || frame_end);
    push_word   = shift_q | (WORD_BITS'(x) << bit_cnt_q);
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (in_valid) begin
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
      if (push) begin
        shift_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shift_d   = push_word;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // FIFO: extra pointer MSB distinguishes full from empty; a pop frees room for a same-cycle push.
  always_comb begin
    empty      = (wr_q == rd_q);
    full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop        = !empty && out_ready;
    push_ok    = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_d       = wr_q + (AW + 1)'(push_ok);
    rd_d       = rd_q + (AW + 1)'(pop);
    head       = mem_q[rd_q[AW-1:0]];
    out_valid  = !empty;
    out_data   = out_valid ? head[WORD_BITS-1:0] : '0;
    out_last   = out_valid & head[WORD_BITS];
    overflow   = overflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= {frame_end, push_word};
  end

`ifdef TURBO_PACKER_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q + 16'(pop && out_last);
    frame_count   = frame_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_count_q <= '0;
    else        frame_count_q <= frame_count_d;
  end
`endif

endmodule

// File: tb/tb_turbo_frame_packer.sv
// Two packers (N=8 and N=10, WORD_BITS=4, FIFO_DEPTH=4) share one stimulus stream and are
// checked every cycle against a frame-position model, plus literal word logs per scenario.
module tb_turbo_frame_packer;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, x = 1'b0, out_ready = 1'b0;
  logic ov0, ol0, of0, ov1, ol1, of1;
  logic [3:0] od0, od1;
`ifdef TURBO_PACKER_FRAME_COUNT_EN
  logic [15:0] fc0, fc1;
`endif

  always #5 clk = ~clk;

  turbo_frame_packer #(.N(8), .WORD_BITS(4), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_last(ol0),
`ifdef TURBO_PACKER_FRAME_COUNT_EN
    .frame_count(fc0),
`endif
    .overflow(of0));

  turbo_frame_packer #(.N(10), .WORD_BITS(4), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_last(ol1),
`ifdef TURBO_PACKER_FRAME_COUNT_EN
    .frame_count(fc1),
`endif
    .overflow(of1));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 10;
  endfunction

  // Model: word boundaries follow from the bit's position inside its frame; FIFO is a bounded list.
  int         mpos [2];
  logic [3:0] macc [2];
  logic [4:0] mf   [2][4];
  int         mc   [2];
  bit         mov  [2];
  int         mfc  [2];
  int         wp;
  bit         fe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mpos[d] = 0; macc[d] = '0; mc[d] = 0; mov[d] = 1'b0; mfc[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mc[d] > 0 && out_ready) begin
          if (mf[d][0][4]) mfc[d]++;
          for (int i = 0; i < 3; i++) mf[d][i] = mf[d][i+1];
          mc[d]--;
        end
        if (in_valid) begin
          wp = mpos[d] % 4;
          fe = (mpos[d] == n_of(d) - 1);
          macc[d][wp] = x;
          if (wp == 3 || fe) begin
            if (mc[d] < 4) begin
              mf[d][mc[d]] = {fe, macc[d]};
              mc[d]++;
            end else begin
              mov[d] = 1'b1;
            end
            macc[d] = '0;
          end
          mpos[d] = fe ? 0 : mpos[d] + 1;
        end
      end
    end
  end

  task automatic cmp(input int d, input logic v, input logic [3:0] dt, input logic l,
                     input logic o, input logic [15:0] fc);
    chk($sformatf("valid%0d", d), v, mc[d] > 0);
    if (mc[d] > 0) begin
      chk($sformatf("data%0d", d), dt, mf[d][0][3:0]);
      chk($sformatf("last%0d", d), l, mf[d][0][4]);
    end
    chk($sformatf("overflow%0d", d), o, mov[d]);
`ifdef TURBO_PACKER_FRAME_COUNT_EN
    chk($sformatf("frame_count%0d", d), fc, 16'(mfc[d]));
`else
    if (fc != 16'h0) chk("fc_tie", fc, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
`ifdef TURBO_PACKER_FRAME_COUNT_EN
      cmp(0, ov0, od0, ol0, of0, fc0);
      cmp(1, ov1, od1, ol1, of1, fc1);
`else
      cmp(0, ov0, od0, ol0, of0, 16'h0);
      cmp(1, ov1, od1, ol1, of1, 16'h0);
`endif
    end
  end

  // Log of popped words {last, data} per DUT, cleared by reset.
  logic [4:0] lg [2][16];
  int         ln [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ln[0] = 0; ln[1] = 0;
    end else begin
      if (ov0 && out_ready && ln[0] < 16) begin lg[0][ln[0]] = {ol0, od0}; ln[0]++; end
      if (ov1 && out_ready && ln[1] < 16) begin lg[1][ln[1]] = {ol1, od1}; ln[1]++; end
    end
  end

  task automatic cyc(input logic v, input logic b, input logic r);
    @(negedge clk); #1;
    in_valid = v; x = b; out_ready = r;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input bit gap, input logic r);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, bits[i], r);
      if (gap) cyc(1'b0, 1'b0, r);
    end
  endtask

  task automatic idle(input int k, input logic r);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; x = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_log(input string name, input int d, input int n, input logic [4:0] w0,
                         input logic [4:0] w1, input logic [4:0] w2);
    logic [4:0] exp [3];
    exp = '{w0, w1, w2};
    chk({name, "_count"}, ln[d], n);
    for (int i = 0; i < n && i < 3; i++) chk($sformatf("%s_w%0d", name, i), lg[d][i], exp[i]);
  endtask

  initial begin
    // Basic pack with latency check on the first word.
    do_reset();
    chk("reset_valid", ov0, 0);
    chk("reset_overflow", of0, 0);
    send(32'h5, 3, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_latency_valid", ov0, 0);
    #1 in_valid = 1'b1; x = 1'b1;
    @(negedge clk);
    chk("latency_valid", ov0, 1);
    chk("latency_data", od0, 4'hD);
    #1 in_valid = 1'b0;
    send(32'h4, 4, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk_log("basic", 0, 2, 5'h0D, 5'h14, 5'h00);

    // Padding on the N=10 packer.
    do_reset();
    send(32'h3FF, 10, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk_log("pad", 1, 3, 5'h0F, 5'h0F, 5'h13);

    // Gapped input.
    do_reset();
    send(32'h4D, 8, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk_log("gap", 0, 2, 5'h0D, 5'h14, 5'h00);

    // Backpressure and overflow.
    do_reset();
    send(32'hA54D, 16, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("full_no_ovf", of0, 0);
    chk("full_head", od0, 4'hD);
    send(32'h6, 4, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("ovf_set", of0, 1);
    send(32'h3, 4, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("ovf_head_stable", od0, 4'hD);
    chk("ovf_valid_held", ov0, 1);
    idle(8, 1'b1);
    chk("drain_count", ln[0], 4);
    chk("drain_w2", lg[0][2], 5'h05);
    chk("drain_w3", lg[0][3], 5'h1A);
    chk("ovf_sticky", of0, 1);

    // Full FIFO with a pop on the cycle a word completes.
    do_reset();
    send(32'hA54D, 16, 1'b0, 1'b0);
    idle(1, 1'b0);
    send(32'h6, 3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("pushpop_no_ovf", of0, 0);
    chk("pushpop_head", od0, 4'h4);
    idle(6, 1'b1);
    send(32'h3, 4, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("pushpop_count", ln[0], 6);
    chk("pushpop_w0", lg[0][0], 5'h0D);
    chk("pushpop_w3", lg[0][3], 5'h1A);
    chk("pushpop_w4", lg[0][4], 5'h06);
    chk("pushpop_w5", lg[0][5], 5'h13);

    // Reset in the middle of a frame.
    do_reset();
    send(32'h15, 5, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("midrst_pre_valid", ov0, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_data", od0, 0);
    chk("rst_last", ol0, 0);
    chk("rst_overflow", of0, 0);
`ifdef TURBO_PACKER_FRAME_COUNT_EN
    chk("rst_frame_count", fc0, 0);
`endif
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    send(32'h4D, 8, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk_log("midrst", 0, 2, 5'h0D, 5'h14, 5'h00);
`ifdef TURBO_PACKER_FRAME_COUNT_EN
    chk("frame_count_one", fc0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
